// File: rtl/sweep_pkg.sv
// Shared types for the counter sweep controller: FSM state encoding and direction constants.
// Latency: n/a (types and constants only).
// Backpressure: n/a. The HOLD state exists only when SWEEP_DWELL_EN is defined.
package sweep_pkg;

    localparam logic DIR_UP   = 1'b1;
    localparam logic DIR_DOWN = 1'b0;

`ifdef SWEEP_DWELL_EN
    typedef enum logic [2:0] {
        IDLE = 3'd0,
        SEEK = 3'd1,
        UP   = 3'd2,
        DOWN = 3'd3,
        HOLD = 3'd4,
        FIN  = 3'd5
    } state_t;
`else
    typedef enum logic [2:0] {
        IDLE = 3'd0,
        SEEK = 3'd1,
        UP   = 3'd2,
        DOWN = 3'd3,
        FIN  = 3'd5
    } state_t;
`endif

endpackage

// File: rtl/sweep_ctrl.sv
// Sequences an external up/down counter: seek to lo, sweep lo->hi->lo 'cycles' times, then pulse done.
// Latency: cnt_enb/cnt_dir are combinational from state and count; busy/done/err are registered (1 cycle).
// Backpressure: none; start is ignored while busy, and abort drops cnt_enb in the same cycle. Optional endpoint hold: SWEEP_DWELL_EN.
module sweep_ctrl
    import sweep_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CYC_W = 4,
    parameter int DWELL = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic [WIDTH-1:0] lo,
    input  logic [WIDTH-1:0] hi,
    input  logic [CYC_W-1:0] cycles,
    input  logic [WIDTH-1:0] count,
    output logic             cnt_enb,
    output logic             cnt_dir,
    output logic             busy,
    output logic             done,
    output logic             err
);

    // A hold of zero cycles cannot be expressed by the HOLD state.
    if (DWELL < 1) begin : g_bad_dwell
        $error("sweep_ctrl: DWELL must be at least 1");
    end

    state_t           state, state_nxt;
    logic [WIDTH-1:0] lo_q, lo_nxt;
    logic [WIDTH-1:0] hi_q, hi_nxt;
    logic [CYC_W-1:0] rem_q, rem_nxt;
    logic             err_nxt;
    logic             out_rng;

`ifdef SWEEP_DWELL_EN
    localparam int DW_W = (DWELL > 1) ? $clog2(DWELL) : 1;
    logic [DW_W-1:0]  dwell_q, dwell_nxt;
    logic             hold_dir_q, hold_dir_nxt;
`endif

    assign out_rng = (count < lo_q) || (count > hi_q);

    // Next-state and counter drive; abort beats every other transition in busy states.
    always_comb begin
        state_nxt = state;
        lo_nxt    = lo_q;
        hi_nxt    = hi_q;
        rem_nxt   = rem_q;
        err_nxt   = 1'b0;
        cnt_enb   = 1'b0;
        cnt_dir   = DIR_DOWN;
`ifdef SWEEP_DWELL_EN
        dwell_nxt    = dwell_q;
        hold_dir_nxt = hold_dir_q;
`endif
        if (state != IDLE && abort) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        if (lo >= hi || cycles == '0) begin
                            err_nxt = 1'b1;
                        end else begin
                            lo_nxt    = lo;
                            hi_nxt    = hi;
                            rem_nxt   = cycles;
                            state_nxt = SEEK;
                        end
                    end
                end
                SEEK: begin
                    cnt_enb = 1'b1;
                    if (count > lo_q) begin
                        cnt_dir = DIR_DOWN;
                    end else begin
                        cnt_dir = DIR_UP;
                        // Reaching lo already steps up this cycle, so no dead cycle.
                        if (count == lo_q) state_nxt = UP;
                    end
                end
                UP: begin
                    if (out_rng) begin
                        err_nxt   = 1'b1;
                        state_nxt = IDLE;
                    end else if (count == hi_q) begin
`ifdef SWEEP_DWELL_EN
                        dwell_nxt    = DW_W'(DWELL - 1);
                        hold_dir_nxt = DIR_DOWN;
                        state_nxt    = HOLD;
`else
                        cnt_enb   = 1'b1;
                        cnt_dir   = DIR_DOWN;
                        state_nxt = DOWN;
`endif
                    end else begin
                        cnt_enb = 1'b1;
                        cnt_dir = DIR_UP;
                    end
                end
                DOWN: begin
                    if (out_rng) begin
                        err_nxt   = 1'b1;
                        state_nxt = IDLE;
                    end else if (count == lo_q) begin
                        rem_nxt = rem_q - CYC_W'(1);
                        if (rem_q == CYC_W'(1)) begin
                            state_nxt = FIN;
                        end else begin
`ifdef SWEEP_DWELL_EN
                            dwell_nxt    = DW_W'(DWELL - 1);
                            hold_dir_nxt = DIR_UP;
                            state_nxt    = HOLD;
`else
                            cnt_enb   = 1'b1;
                            cnt_dir   = DIR_UP;
                            state_nxt = UP;
`endif
                        end
                    end else begin
                        cnt_enb = 1'b1;
                        cnt_dir = DIR_DOWN;
                    end
                end
`ifdef SWEEP_DWELL_EN
                HOLD: begin
                    // The endpoint cycle that entered HOLD is the first held cycle,
                    // so the last HOLD cycle already moves off the endpoint.
                    if (out_rng) begin
                        err_nxt   = 1'b1;
                        state_nxt = IDLE;
                    end else if (dwell_q == '0) begin
                        cnt_enb   = 1'b1;
                        cnt_dir   = hold_dir_q;
                        state_nxt = (hold_dir_q == DIR_UP) ? UP : DOWN;
                    end else begin
                        dwell_nxt = dwell_q - DW_W'(1);
                    end
                end
`endif
                FIN: begin
                    state_nxt = IDLE;
                end
                default: begin
                    state_nxt = IDLE;
                end
            endcase
        end
    end

    // State, captured bounds and registered status flags.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            lo_q  <= '0;
            hi_q  <= '0;
            rem_q <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
            err   <= 1'b0;
        end else begin
            state <= state_nxt;
            lo_q  <= lo_nxt;
            hi_q  <= hi_nxt;
            rem_q <= rem_nxt;
            busy  <= (state_nxt != IDLE);
            done  <= (state_nxt == FIN);
            err   <= err_nxt;
        end
    end

`ifdef SWEEP_DWELL_EN
    // Endpoint hold counter and the direction to resume in.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            dwell_q    <= '0;
            hold_dir_q <= DIR_DOWN;
        end else begin
            dwell_q    <= dwell_nxt;
            hold_dir_q <= hold_dir_nxt;
        end
    end
`endif

endmodule

// File: doc/sweep_ctrl.md
Name: sweep_ctrl

Overview:
Controller that sequences the team's 8-bit up/down counter by driving its enable and direction inputs and observing its count value. On a start command it seeks the counter to a programmable low bound. It then sweeps lo→hi→lo a programmed number of times and signals completion. It sits beside the counter; the counter itself is unchanged.

Parameters:
WIDTH, 8, width of the observed count and the lo/hi bounds
CYC_W, 4, width of the sweep-repetition count
DWELL, 3, endpoint hold cycles; used only with SWEEP_DWELL_EN, must be ≥1

Ports:
clk  in  1  single clock; all state updates on the rising edge
rst  in  1  asynchronous, active-low reset
start  in  1  command strobe; honoured only in IDLE
abort  in  1  synchronous abort of a running sweep
lo  in  WIDTH  low bound, captured on an accepted start
hi  in  WIDTH  high bound, captured on an accepted start
cycles  in  CYC_W  number of lo→hi→lo sweeps, captured on an accepted start
count  in  WIDTH  current counter value
cnt_enb  out  1  drives the counter's enable
cnt_dir  out  1  drives the counter's direction: 1 = up, 0 = down
busy  out  1  high in every state except IDLE
done  out  1  single-cycle pulse on normal completion
err  out  1  single-cycle pulse on a rejected command or an out-of-range count

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE; captured registers = 0; cnt_enb=0, cnt_dir=0, busy=0, done=0, err=0. This takes effect immediately, including mid-sweep.
- cnt_enb and cnt_dir are combinational from the registered state and the count input, so the counter moves on the same edge the state advances. There is no overshoot. done, err and busy are registered.
- IDLE: cnt_enb=0. On start=1:
  - if lo≥hi or cycles==0: err pulses next cycle and the block stays IDLE;
  - otherwise: capture lo, hi, cycles into rem, then go to SEEK.
- SEEK:
  - count<lo: enb=1, dir=1.
  - count>lo: enb=1, dir=0.
  - count==lo: enb=1, dir=1, go to UP (no dead cycle).
- UP: enb=1, dir=1. When count==hi: drive dir=0 that cycle and go to DOWN (zero-cycle turnaround).
- DOWN: enb=1, dir=0. When count==lo: rem is decremented.
  - If the new rem==0: enb=0, go to FIN.
  - Otherwise: dir=1, go to UP.
- FIN: enb=0; done=1 for exactly one cycle; then IDLE.
- Range guard: in UP or DOWN, count<lo or count>hi forces enb=0, err pulse, and return to IDLE with no done.
- abort=1 in any busy state: enb=0 combinationally that cycle; IDLE next cycle; no done, no err. abort has priority over all transitions. In IDLE, abort has no effect.
- start while busy is ignored. Simultaneous start and abort in IDLE: start wins.
- Timing: one sweep takes 2·(hi−lo) enabled cycles. Seek takes |count−lo| cycles.
- Arithmetic: all comparisons are unsigned. rem is CYC_W bits and never wraps, because cycles==0 is rejected.

Optional Feature:
SWEEP_DWELL_EN
- Defined: UP at count==hi and DOWN at count==lo (when rem≠0 after the decrement) enter a HOLD state instead of turning around.
  - HOLD: enb=0 for DWELL cycles, then resume in the opposite direction.
  - The final return to lo goes straight to FIN with no hold.
  - abort and the range guard also apply in HOLD.
- Undefined: no HOLD state exists; turnaround is zero-cycle as specified above.

Decomposition:
- Package sweep_pkg:
  - state enum typedef (IDLE, SEEK, UP, DOWN, HOLD, FIN); HOLD is present only under SWEEP_DWELL_EN;
  - DIR_UP=1'b1 and DIR_DOWN=1'b0 constants.
- No sub-module: a single FSM module with a rem register and, under the macro, a dwell counter.
- The bench instantiates the existing counter beside sweep_ctrl.

Test Plan:
1. rst=0 held mid-sweep → cnt_enb=0, busy=0, done=0, err=0 immediately; after release the block sits in IDLE.
2. count=0; start with lo=2, hi=5, cycles=1 → 2 seek cycles (0→2), 3 up (2→5), 3 down (5→2); done pulses once, count rests at 2, busy falls.
3. start with lo=5, hi=5, cycles=2; then lo=1, hi=4, cycles=0 → err pulses each time, busy stays 0, cnt_enb stays 0.
4. count=0; start with lo=0, hi=3, cycles=3 → count traces 0,1,2,3,2,1,0 three times (18 enabled cycles); exactly one done.
5. abort asserted when count=4 in UP (lo=2, hi=7) → cnt_enb=0 that cycle, count frozen at 4, busy=0 next cycle, no done; start pulsed while busy earlier in the run was ignored.
6. Counter forced to 200, then start with lo=10, hi=20, cycles=1 → seek down 190 cycles with dir=0; force count=25 during UP → err pulse, IDLE. Under SWEEP_DWELL_EN with DWELL=3: cnt_enb=0 for exactly 3 cycles at hi.
